// File: rtl/serial_adder_pkg.sv
// Purpose : shared definitions for the bit-serial adder (FSM encoding, counter sizing).
// Latency : n/a (package only).
// Backpressure : n/a (package only).
package serial_adder_pkg;

    // Controller states. busy is high in ADD and DONE, done only in DONE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit-counter width for an n-bit operand: enough to hold the values 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/b2_adder_p.sv
// Purpose : 1-bit gate-level full adder.
// Latency : combinational, zero cycles.
// Backpressure : none.
//
// Ports:
//   a, b  - addend bits
//   ci    - carry in
//   s     - sum bit (a ^ b ^ ci)
//   co    - carry out (majority of a, b, ci)
module b2_adder_p (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    wire p;     // propagate
    wire g;     // generate
    wire t;     // carry through propagate
    wire s_w;
    wire co_w;

    xor u_xor_p  (p,    a,  b);
    xor u_xor_s  (s_w,  p,  ci);
    and u_and_g  (g,    a,  b);
    and u_and_t  (t,    p,  ci);
    or  u_or_co  (co_w, g,  t);

    assign s  = s_w;
    assign co = co_w;

endmodule

// File: rtl/serial_adder.sv
// Purpose : bit-serial N-bit adder, one bit per clock through a single full adder.
// Latency : start accepted at edge 0, bits at edges 1..N, done pulses the cycle after edge N.
// Backpressure : none; start is ignored while busy (no queuing), one add per N+2 cycles.
//
// Ports:
//   clock, reset_ - rising-edge clock, asynchronous active-low reset
//   x, y, cin     - operands and carry-in, sampled only on the accepting edge
//   start         - level-sampled request to begin an addition (honoured in IDLE only)
//   busy          - high while adding or signalling the result
//   s, cout       - result of the last completed addition, held until the next start
//   done          - one-cycle pulse when s/cout carry a new result
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    input  logic         start,
    output logic         busy,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         done
);

    typedef logic [cnt_width(N)-1:0] cnt_t;

    state_e       state_q;
    logic [N-1:0] x_q;
    logic [N-1:0] y_q;
    logic [N-1:0] s_q;
    logic [N-1:0] s_d;
    logic         c_q;
    logic         cout_q;
    logic         done_q;
    logic         busy_q;
    cnt_t         cnt_q;

    logic         fa_s;
    logic         fa_c;

    // The only arithmetic in the block: LSBs of both operands plus the carry flop.
    b2_adder_p u_fa (
        .a  (x_q[0]),
        .b  (y_q[0]),
        .ci (c_q),
        .s  (fa_s),
        .co (fa_c)
    );

    // New sum bit enters at the MSB; after N shifts bit 0 of the result
    // has travelled down to s[0]. Written without part-selects so N=1 works.
    always_comb begin
        s_d = (s_q >> 1) | (N'(fa_s) << (N - 1));
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q     <= x;
                        y_q     <= y;
                        c_q     <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ADD;
                    end
                end

                ADD: begin
                    s_q   <= s_d;
                    c_q   <= fa_c;
                    x_q   <= x_q >> 1;
                    y_q   <= y_q >> 1;
                    cnt_q <= cnt_q + cnt_t'(1);
                    // Last bit: publish the final carry and raise done next cycle.
                    if (cnt_q == cnt_t'(N - 1)) begin
                        cout_q  <= fa_c;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end

                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign s    = s_q;
    assign cout = cout_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic       clock;
    logic       reset_;
    logic [7:0] x, y;
    logic       cin, start;
    logic       busy, cout, done;
    logic [7:0] s;

    logic [0:0] x1, y1;
    logic       cin1, start1;
    logic       busy1, cout1, done1;
    logic [0:0] s1;

    serial_adder #(.N(8)) dut (
        .clock(clock), .reset_(reset_), .x(x), .y(y), .cin(cin), .start(start),
        .busy(busy), .s(s), .cout(cout), .done(done)
    );

    serial_adder #(.N(1)) dut1 (
        .clock(clock), .reset_(reset_), .x(x1), .y(y1), .cin(cin1), .start(start1),
        .busy(busy1), .s(s1), .cout(cout1), .done(done1)
    );

    typedef struct {
        logic [7:0] s;
        logic       cout;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t q1[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitors: every done pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                check("n8_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("n8_sum", {24'd0, s}, {24'd0, e.s});
                check("n8_cout", {31'd0, cout}, {31'd0, e.cout});
                check("n8_done_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clock) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("n1_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("n1_sum", {31'd0, s1}, {24'd0, e.s});
                check("n1_cout", {31'd0, cout1}, {31'd0, e.cout});
                check("n1_done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drain(input string name);
        int n = 0;
        while ((q.size() != 0 || q1.size() != 0) && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (q.size() != 0 || q1.size() != 0) begin
            check({name, "_timeout"}, 32'd1, 32'd0);
            q.delete();
            q1.delete();
        end
    endtask

    // Issue one N=8 add; operands are scrambled right after acceptance.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [7:0] es, input logic ec);
        exp_t e;
        @(negedge clock);
        x = a; y = b; cin = c; start = 1'b1;
        e.s = es; e.cout = ec; e.cyc = cyc + 1 + 8;
        q.push_back(e);
        @(negedge clock);
        start = 1'b0;
        x = 8'($urandom); y = 8'($urandom); cin = 1'($urandom);
        check("busy_in_add", {31'd0, busy}, 32'd1);
    endtask

    task automatic issue1(input logic a, input logic b, input logic c,
                          input logic es, input logic ec);
        exp_t e;
        @(negedge clock);
        x1 = a; y1 = b; cin1 = c; start1 = 1'b1;
        e.s = {7'd0, es}; e.cout = ec; e.cyc = cyc + 1 + 1;
        q1.push_back(e);
        @(negedge clock);
        start1 = 1'b0;
        x1 = ~a; y1 = ~b; cin1 = ~c;
        check("n1_busy", {31'd0, busy1}, 32'd1);
    endtask

    initial begin
        int e0;
        x = 8'd0; y = 8'd0; cin = 1'b0; start = 1'b0;
        x1 = 1'b0; y1 = 1'b0; cin1 = 1'b0; start1 = 1'b0;
        reset_ = 1'b1;
        #1 reset_ = 1'b0;
        #1;
        check("rst_s", {24'd0, s}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clock);
        reset_ = 1'b1;
        @(negedge clock);

        // Basic sums and carry-out cases.
        issue(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        drain("add_5a_3c");
        issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        drain("add_ff_01");
        issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        drain("add_ff_ff_1");
        @(negedge clock);
        check("idle_hold_s", {24'd0, s}, 32'h0000_00FF);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Starts during ADD must be ignored.
        @(negedge clock);
        x = 8'h10; y = 8'h20; cin = 1'b0; start = 1'b1;
        e0 = cyc + 1;
        q.push_back('{8'h30, 1'b0, e0 + 8});
        while (cyc < e0 + 8) begin
            @(negedge clock);
            start = (cyc == e0 + 2 || cyc == e0 + 7);
            if (cyc == e0) begin x = 8'hAA; y = 8'h55; cin = 1'b1; end
            if (cyc == e0 + 4) check("busy_mid_add", {31'd0, busy}, 32'd1);
        end
        start = 1'b0;
        drain("ignored_start");
        repeat (15) @(negedge clock);
        check("no_second_result_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of an addition.
        @(negedge clock);
        x = 8'h33; y = 8'h44; cin = 1'b0; start = 1'b1;
        e0 = cyc + 1;
        @(negedge clock);
        start = 1'b0;
        while (cyc < e0 + 3) @(negedge clock);
        reset_ = 1'b0;
        #1;
        check("abort_s", {24'd0, s}, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clock);
        reset_ = 1'b1;
        repeat (12) @(negedge clock);
        issue(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
        drain("after_abort");

        // start held high: one result every N+2 = 10 cycles.
        @(negedge clock);
        x = 8'h80; y = 8'h80; cin = 1'b0; start = 1'b1;
        e0 = cyc + 1;
        q.push_back('{8'h00, 1'b1, e0 + 8});
        q.push_back('{8'h00, 1'b1, e0 + 18});
        q.push_back('{8'h00, 1'b1, e0 + 28});
        while (cyc < e0 + 20) begin
            @(negedge clock);
            if (cyc == e0 + 9 || cyc == e0 + 19) begin
                check("held_stable_s", {24'd0, s}, 32'd0);
                check("held_stable_cout", {31'd0, cout}, 32'd1);
            end
        end
        start = 1'b0;
        drain("held_start");
        repeat (12) @(negedge clock);

        // N=1 instance: ADD lasts a single edge.
        issue1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        drain("n1_111");
        issue1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drain("n1_100");
        repeat (4) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
